// File: rtl/univ_cnt_sequencer_pkg.sv
// Shared opcodes, state encoding and default widths for the counter sequencer.
package univ_cnt_sequencer_pkg;

  localparam int N_DEF  = 8;
  localparam int PW_DEF = 16;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLR    = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_RUN_UP = 3'd3;
  localparam logic [2:0] OP_RUN_DN = 3'd4;
  localparam logic [2:0] OP_BOUNCE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_RUN_UP = 2'd2,
    ST_RUN_DN = 2'd3
  } state_t;

  // Which single-cycle strobe a PULSE state issues.
  typedef enum logic [1:0] {
    PK_NOP  = 2'd0,
    PK_CLR  = 2'd1,
    PK_LOAD = 2'd2
  } pulse_t;

endpackage

// File: rtl/univ_cnt_sequencer_prescaler.sv
// Step pacer: due fires once every (div+1) cycles while run is high.
module cnt_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          run,
  input  logic [PW-1:0] div,
  output logic          due
);

  logic [PW-1:0] pcnt;

  assign due = run & (pcnt == div);

  // Free-running modulo-(div+1) phase counter, parked at 0 when idle or cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 pcnt <= '0;
    else if (clear || !run)    pcnt <= '0;
    else if (pcnt == div)      pcnt <= '0;
    else                       pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/univ_cnt_sequencer.sv
// Command-driven controller for a universal up/down counter. Runs stop at
// max_tick/min_tick so the counter never wraps under sequencer control.
module univ_cnt_sequencer
  import univ_cnt_sequencer_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [N-1:0]  cmd_data,
  input  logic [PW-1:0] cmd_div,
  input  logic          abort,
  input  logic          max_tick,
  input  logic          min_tick,
  output logic          syn_clr,
  output logic          load,
  output logic          en,
  output logic          up,
  output logic [N-1:0]  d,
  output logic          busy,
  output logic          done_tick
);

  state_t        state, state_nx;
  pulse_t        pk_r;
  logic          bounce_r;
  logic [PW-1:0] div_r;
  logic          accept, run, due, turn, pclear;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign run       = (state == ST_RUN_UP) | (state == ST_RUN_DN);
  // pcnt restarts on bounce turnaround and is held at 0 in every non-run state.
  assign pclear    = turn | ((state_nx != ST_RUN_UP) & (state_nx != ST_RUN_DN));

  cnt_prescaler #(.PW(PW)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (pclear),
    .run   (run),
    .div   (div_r),
    .due   (due)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and counter strobes; abort outranks the boundary tick.
  always_comb begin
    state_nx  = state;
    syn_clr   = 1'b0;
    load      = 1'b0;
    en        = 1'b0;
    done_tick = 1'b0;
    turn      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RUN_UP, OP_BOUNCE: state_nx = ST_RUN_UP;
            OP_RUN_DN:            state_nx = ST_RUN_DN;
            default:              state_nx = ST_PULSE;
          endcase
        end
      end
      ST_PULSE: begin
        syn_clr   = (pk_r == PK_CLR);
        load      = (pk_r == PK_LOAD);
        done_tick = 1'b1;
        state_nx  = ST_IDLE;
      end
      ST_RUN_UP: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (max_tick) begin
          if (bounce_r) begin
            turn     = 1'b1;
            state_nx = ST_RUN_DN;
          end else begin
            done_tick = 1'b1;
            state_nx  = ST_IDLE;
          end
        end else begin
          en = due;
        end
      end
      ST_RUN_DN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (min_tick) begin
          done_tick = 1'b1;
          state_nx  = ST_IDLE;
        end else begin
          en = due;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Command capture on accept; direction flip on bounce; flag drop on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d        <= '0;
      up       <= 1'b1;
      div_r    <= '0;
      bounce_r <= 1'b0;
      pk_r     <= PK_NOP;
    end else if (accept) begin
      bounce_r <= (cmd_op == OP_BOUNCE);
      pk_r     <= PK_NOP;
      case (cmd_op)
        OP_CLR:  pk_r <= PK_CLR;
        OP_LOAD: begin
          pk_r <= PK_LOAD;
          d    <= cmd_data;
        end
        OP_RUN_UP, OP_BOUNCE: begin
          div_r <= cmd_div;
          up    <= 1'b1;
        end
        OP_RUN_DN: begin
          div_r <= cmd_div;
          up    <= 1'b0;
        end
        default: pk_r <= PK_NOP;
      endcase
    end else begin
      if (turn)                  up       <= 1'b0;
      if (state_nx == ST_IDLE)   bounce_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_univ_cnt_sequencer.sv
// Directed bench: sequencer driving a behavioural 4-bit universal counter.
module tb_univ_cnt_sequencer;
  import univ_cnt_sequencer_pkg::*;

  localparam int N  = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'd0;
  logic [N-1:0]  cmd_data = '0;
  logic [PW-1:0] cmd_div = '0;
  logic          abort = 1'b0;
  logic          max_tick, min_tick;
  logic          syn_clr, load, en, up, busy, done_tick;
  logic [N-1:0]  d;
  logic [N-1:0]  q;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int dn_cnt = 0;
  int e0, d0;

  always #5 clk = ~clk;

  univ_cnt_sequencer #(.N(N), .PW(PW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_div(cmd_div), .abort(abort),
    .max_tick(max_tick), .min_tick(min_tick), .syn_clr(syn_clr), .load(load),
    .en(en), .up(up), .d(d), .busy(busy), .done_tick(done_tick)
  );

  // Universal up/down counter the sequencer drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        q <= '0;
    else if (syn_clr) q <= '0;
    else if (load)    q <= d;
    else if (en)      q <= up ? q + 1'b1 : q - 1'b1;
  end
  assign max_tick = (q == '1);
  assign min_tick = (q == '0);

  // Pulse tallies.
  always @(posedge clk) begin
    if (en)        en_cnt <= en_cnt + 1;
    if (done_tick) dn_cnt <= dn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns in the first cycle after accept.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] data, input logic [PW-1:0] div);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_div   = div;
    tick;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick; tick;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_up", up, 1);
    chk("rst_d", d, 0);
    chk("rst_done", done_tick, 0);
    chk("rst_strobes", {syn_clr, load}, 0);
    reset = 1'b0;
    tick;

    // LOAD 9
    issue(OP_LOAD, 4'd9, '0);
    chk("ld_load", load, 1);
    chk("ld_d", d, 9);
    chk("ld_done", done_tick, 1);
    chk("ld_busy", busy, 1);
    chk("ld_noclr_noen", {syn_clr, en}, 0);
    chk("ld_ready_c1", cmd_ready, 0);
    tick;
    chk("ld_ready_c2", cmd_ready, 1);
    chk("ld_done_c2", done_tick, 0);
    chk("ld_q", q, 9);

    // CLR, then RUN_UP div=2 from 0: en at 3,6..45, done at 46
    issue(OP_CLR, '0, '0);
    chk("clr_syn", syn_clr, 1);
    chk("clr_done", done_tick, 1);
    chk("clr_noload", load, 0);
    tick;
    chk("clr_q", q, 0);
    issue(OP_RUN_UP, '0, 16'd2);
    for (int c = 1; c <= 46; c++) begin
      chk($sformatf("up_en_c%0d", c), en, ((c % 3 == 0) && (c <= 45)) ? 1 : 0);
      chk($sformatf("up_done_c%0d", c), done_tick, (c == 46) ? 1 : 0);
      if (c < 46) tick;
    end
    chk("up_max_c46", max_tick, 1);
    tick;
    chk("up_idle", busy, 0);
    chk("up_q", q, 15);

    // BOUNCE div=0 from 13: 2 up steps, turn, 15 down steps, done
    issue(OP_LOAD, 4'd13, '0);
    tick;
    chk("bn_q0", q, 13);
    e0 = en_cnt; d0 = dn_cnt;
    issue(OP_BOUNCE, '0, 16'd0);
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("bn_en_c%0d", c), en, ((c <= 2) || (c >= 4 && c <= 18)) ? 1 : 0);
      chk($sformatf("bn_up_c%0d", c), up, (c <= 3) ? 1 : 0);
      chk($sformatf("bn_done_c%0d", c), done_tick, (c == 19) ? 1 : 0);
      if (c < 19) tick;
    end
    tick;
    chk("bn_idle", busy, 0);
    chk("bn_q", q, 0);
    chk("bn_en_total", en_cnt - e0, 17);
    chk("bn_done_total", dn_cnt - d0, 1);

    // RUN_DN div=3 at q=0: zero-step completion, valid held while busy
    e0 = en_cnt; d0 = dn_cnt;
    cmd_valid = 1'b1; cmd_op = OP_RUN_DN; cmd_div = 16'd3;
    tick;
    chk("dn0_done", done_tick, 1);
    chk("dn0_en", en, 0);
    chk("dn0_busy", busy, 1);
    tick;
    chk("dn0_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    tick;
    chk("dn0_no_reaccept", busy, 0);
    chk("dn0_en_total", en_cnt - e0, 0);
    chk("dn0_done_total", dn_cnt - d0, 1);

    // RUN_UP div=1 from 5, abort after 3 steps
    issue(OP_LOAD, 4'd5, '0);
    tick;
    d0 = dn_cnt;
    issue(OP_RUN_UP, '0, 16'd1);
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("ab_en_c%0d", c), en, (c % 2 == 0) ? 1 : 0);
      tick;
    end
    chk("ab_q_pre", q, 8);
    abort = 1'b1;
    #1;
    chk("ab_en", en, 0);
    chk("ab_done", done_tick, 0);
    chk("ab_busy", busy, 1);
    tick;
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_q", q, 8);
    chk("ab_no_done", dn_cnt - d0, 0);
    abort = 1'b1;
    chk("ab_idle_ready", cmd_ready, 1);
    tick;
    abort = 1'b0;
    chk("ab_idle_busy", busy, 0);
    chk("ab_idle_done", done_tick, 0);
    chk("ab_idle_q", q, 8);

    // Reset asserted mid-RUN_UP while en pulses
    issue(OP_RUN_UP, '0, 16'd0);
    chk("mr_en_c1", en, 1);
    tick;
    chk("mr_en_c2", en, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("mr_en", en, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_up", up, 1);
    chk("mr_d", d, 0);
    d0 = dn_cnt;
    tick;
    reset = 1'b0;
    tick; tick; tick;
    chk("mr_no_done", dn_cnt - d0, 0);
    chk("mr_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_cnt_sequencer.md
Name: univ_cnt_sequencer

Overview:
- Command-driven controller directly upstream of the universal up/down binary counter.
- Accepts one command at a time over a valid/ready handshake.
- Drives the counter's syn_clr, load, en, up and d inputs, with en paced by a programmable prescaler.
- Uses the counter's max_tick/min_tick feedback to stop runs at the boundaries, so the counter never wraps under sequencer control.

Parameters:
- N, 8, counter width; must match the width of the driven counter.
- PW, 16, prescaler width; counter step period is (div+1) clk cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode: 0 NOP, 1 CLR, 2 LOAD, 3 RUN_UP, 4 RUN_DN, 5 BOUNCE, 6-7 treated as NOP
- cmd_data  in  N  load value for LOAD
- cmd_div  in  PW  prescaler divisor, captured for RUN_UP/RUN_DN/BOUNCE
- abort  in  1  terminate a run in progress
- max_tick  in  1  from counter: count is all ones
- min_tick  in  1  from counter: count is zero
- syn_clr  out  1  to counter
- load  out  1  to counter
- en  out  1  to counter
- up  out  1  to counter
- d  out  N  to counter
- busy  out  1  command in progress (not IDLE)
- done_tick  out  1  one-cycle pulse when a command completes normally

Behaviour:
- Reset state:
  - FSM in IDLE; div_r=0, pcnt=0, d=0, up=1.
  - syn_clr=load=en=done_tick=busy=0, cmd_ready=1.
- States: IDLE, PULSE, RUN_UP, RUN_DN. The BOUNCE flag register is cleared on reset.
- Handshake:
  - cmd_ready = (state==IDLE), decoded from state only.
  - A command is accepted on a clk edge when cmd_valid & cmd_ready; fields are captured on that edge.
  - cmd_valid while not ready is ignored; the command is not queued.
- NOP and opcodes 6-7: go to PULSE. The next cycle asserts done_tick only, then returns to IDLE.
- CLR: go to PULSE. The cycle after accept asserts syn_clr=1 and done_tick=1 for exactly one cycle, then IDLE.
- LOAD:
  - d <= cmd_data on accept; d holds its value until the next LOAD.
  - The cycle after accept asserts load=1 and done_tick=1 for one cycle, then IDLE.
- RUN_UP / RUN_DN:
  - On accept: div_r <= cmd_div, pcnt <= 0, up <= 1 or 0 respectively.
  - The first run cycle is the cycle after accept.
- Prescaler (run states only):
  - en = (pcnt==div_r) & ~stop, where stop = max_tick in RUN_UP and min_tick in RUN_DN.
  - pcnt wraps to 0 when equal to div_r; otherwise it increments.
  - div_r=0 gives en every cycle.
  - pcnt is held at 0 outside run states.
- Termination:
  - RUN_UP: in any cycle with max_tick=1, en is forced to 0 and the state changes.
  - RUN_DN: the same rule applies with min_tick.
  - If the counter is already at the boundary on the first run cycle, the command completes with zero steps.
- State change on termination:
  - RUN_UP/RUN_DN with BOUNCE flag clear: done_tick=1 that cycle, next state IDLE.
  - BOUNCE is accepted as RUN_UP with the flag set. At max_tick it moves to RUN_DN with up <= 0, pcnt <= 0 and no done_tick. At min_tick in RUN_DN it asserts done_tick, clears the flag and goes to IDLE.
- abort:
  - Sampled in RUN_UP/RUN_DN only; ignored in IDLE and PULSE.
  - In an abort cycle en=0, done_tick=0, and the next state is IDLE; the BOUNCE flag is cleared.
  - If abort and boundary occur in the same cycle, abort wins and no done_tick is issued.
- busy = (state != IDLE).
- Output paths:
  - syn_clr, load, en, done_tick are decoded from registered state, pcnt and the tick inputs.
  - There is no combinational path from cmd_* to any output.
  - max_tick/min_tick reach en combinationally; this is acceptable because both are register-driven.
- Mutual exclusion: syn_clr, load and en are never asserted in the same cycle.
- Reset mid-command: immediate return to reset state; any pulse in flight is dropped.

Decomposition:
- Shared package:
  - opcode constants OP_NOP, OP_CLR, OP_LOAD, OP_RUN_UP, OP_RUN_DN, OP_BOUNCE;
  - state encoding constants;
  - default widths N and PW.
- One sub-module, cnt_prescaler:
  - inputs: clk, reset, clear, run, div[PW-1:0];
  - output: due.
  - The parent gates due with stop/abort to form en.

Test Plan (N=4):
- Reset asserted mid-RUN_UP with en pulsing -> same cycle en=0, busy=0, cmd_ready=1, up=1, d=0; no done_tick after reset release.
- LOAD cmd_data=9 accepted at cycle 0 -> cycle 1: load=1, d=9, done_tick=1, busy=1; cycle 2: cmd_ready=1; counter q=9.
- CLR then RUN_UP cmd_div=2 accepted at cycle 0 with q=0 -> en at cycles 3,6,...,45 (15 pulses); max_tick=1 at cycle 46; cycle 46 en=0, done_tick=1; cycle 47 IDLE; q=15; no wrap.
- BOUNCE cmd_div=0 from q=13 -> en every cycle; up=1 until q=15, then up=0; en continues every cycle until q=0; exactly one done_tick; total 2+15 en pulses.
- RUN_DN cmd_div=3 from q=0 -> done_tick on the first run cycle, zero en pulses; cmd_valid held high during busy is not accepted twice.
- RUN_UP cmd_div=1 from q=5, abort asserted after 3 en pulses -> en=0 in the abort cycle, no done_tick, q=8, IDLE next cycle; abort pulsed in IDLE has no effect.
